// File: rtl/fifo_read_prefetch.sv
// -----------------------------------------------------------------------------
// fifo_read_prefetch
//   Downstream read stage of a two-port-RAM FIFO. It issues reads into the
//   FIFO storage only while a skid slot is guaranteed for the returning word,
//   tracks the reads in flight with a LATENCY-deep valid pipe, captures each
//   returned word into a small circular skid buffer and presents the head of
//   that buffer to the consumer with first-word fall-through.
//
// Ports
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous, active-low reset; all state cleared while low
//   i_src_empty      storage has no readable word
//   o_src_rd_en      read strobe to storage, one word per cycle high
//   i_src_rd_data    storage read data, valid LATENCY cycles after o_src_rd_en
//   i_flush          synchronous discard of skid contents and in-flight reads
//   o_out_valid      o_out_data holds a word
//   i_out_ready      consumer ready
//   o_out_data       head word of the skid buffer (0 when empty)
//   o_out_count      registered skid occupancy
//   o_state          FSM state: 00 IDLE, 01 FILL, 10 STALL, 11 DRAIN
//   o_overflow_err   sticky; a return arrived while the skid was full with no pop
//
// Handshake: a word transfers on every rising edge where o_out_valid and
//   i_out_ready are both high; o_out_valid never depends on i_out_ready, and
//   o_out_data stays stable while o_out_valid is high and no transfer occurs.
// -----------------------------------------------------------------------------
module fifo_read_prefetch #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 3,
    parameter int SKID_DEPTH = 4,
    localparam int CNT_W     = $clog2(SKID_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_src_empty,
    output logic                  o_src_rd_en,
    input  logic [DATA_WIDTH-1:0] i_src_rd_data,
    input  logic                  i_flush,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [CNT_W-1:0]      o_out_count,
    output logic [1:0]            o_state,
    output logic                  o_overflow_err
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int INF_W = $clog2(LATENCY + 1);
    localparam int SUM_W = $clog2(SKID_DEPTH + LATENCY + 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FILL  = 2'b01;
    localparam logic [1:0] ST_STALL = 2'b10;
    localparam logic [1:0] ST_DRAIN = 2'b11;

    logic [LATENCY-1:0]    r_pipe;
    logic [LATENCY-1:0]    w_pipe_next;
    logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_next;
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  r_overflow_err;
    logic [INF_W-1:0]      w_inflight;
    logic [INF_W-1:0]      w_inflight_next;
    logic [SUM_W-1:0]      w_occ;
    logic [SUM_W-1:0]      w_occ_next;
    logic                  w_rd_en;
    logic                  w_tail;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_ovf;

    function automatic logic [INF_W-1:0] popcount(input logic [LATENCY-1:0] v);
        logic [INF_W-1:0] n;
        n = '0;
        for (int i = 0; i < LATENCY; i++) begin
            n = n + INF_W'(v[i]);
        end
        return n;
    endfunction

    // Wrap explicitly so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_inflight = popcount(r_pipe);
    assign w_occ      = SUM_W'(r_count) + SUM_W'(w_inflight);

    // A read is issued only if every slot it could land in is already free
    // counting words held and words in flight. A same-cycle pop earns no
    // credit, so a word holds its credit from issue until the edge that pops it.
    assign w_rd_en = i_rst_n & ~i_src_empty & ~i_flush & (w_occ < SUM_W'(SKID_DEPTH));

    assign w_tail     = r_pipe[LATENCY-1];
    assign w_full     = (r_count == CNT_W'(SKID_DEPTH));
    assign w_pop      = (r_count != '0) & i_out_ready & ~i_flush;
    assign w_push_req = w_tail & ~i_flush;
    // At full, a push fits only because the same edge frees the head slot.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf      = w_push_req & w_full & ~w_pop;

    always_comb begin
        w_pipe_next    = r_pipe << 1;
        w_pipe_next[0] = w_rd_en;
        if (i_flush) begin
            w_pipe_next = '0;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    assign w_inflight_next = popcount(w_pipe_next);
    assign w_occ_next      = SUM_W'(w_count_next) + SUM_W'(w_inflight_next);

    // Next state looks at next-cycle occupancy. A flush zeroes occupancy, so
    // it naturally lands in IDLE (source empty) or FILL (source has data).
    always_comb begin
        w_state_next = ST_IDLE;
        if (i_src_empty) begin
            w_state_next = (w_occ_next == '0) ? ST_IDLE : ST_DRAIN;
        end else begin
            w_state_next = (w_occ_next < SUM_W'(SKID_DEPTH)) ? ST_FILL : ST_STALL;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe         <= '0;
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_count        <= '0;
            r_state        <= ST_IDLE;
            r_overflow_err <= 1'b0;
        end else begin
            r_pipe  <= w_pipe_next;
            r_count <= w_count_next;
            r_state <= w_state_next;
            if (i_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
                if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_ovf) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

    // Storage array needs no reset: an entry is only visible once counted.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_src_rd_data;
        end
    end

    assign o_src_rd_en    = w_rd_en;
    assign o_out_valid    = (r_count != '0);
    assign o_out_data     = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_out_count    = r_count;
    assign o_state        = r_state;
    assign o_overflow_err = r_overflow_err;

endmodule
